// File: rtl/qspi_flash_responder.sv
// Flash-device emulator answering serial (0x03), quad (0xEB) and JEDEC ID (0x9F) reads.
// The SPI clock is oversampled in the clk domain; IO changes on falling SPI edges.
module qspi_flash_responder #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned DUMMY_CYCLES = 6,
   parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_clk,
   input  logic                  cs_n,
   input  logic                  data_in,
   output logic [3:0]            data_out,
   output logic [3:0]            data_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_data
);

   localparam int unsigned CNT_W = 5;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, LOAD, DATA, ID, IGNORE
   } state_t;

   state_t                state, state_nxt;
   logic                  spi_clk_q;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  quad, quad_nxt;
   logic                  armed, armed_nxt;
   logic [23:0]           sr, sr_nxt;
   logic [7:0]            byte_sr, byte_sr_nxt;
   logic [7:0]            next_byte, next_byte_nxt;
   logic                  next_valid, next_valid_nxt;
   logic                  mem_rd_q, mem_rd_q_nxt;
   logic [3:0]            data_out_nxt, data_oe_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic                  mem_rd_nxt;
   logic                  load;

   logic        rise, fall, last_bit;
   logic [23:0] sr_in;
   logic [7:0]  fetch_byte;

   assign rise       = spi_clk & ~spi_clk_q & ~cs_n;
   assign fall       = ~spi_clk & spi_clk_q & ~cs_n;
   assign sr_in      = {sr[22:0], data_in};
   assign fetch_byte = mem_rd_q ? mem_data : next_byte;
   assign last_bit   = quad ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(7));

   // Next-state and registered-output logic
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      quad_nxt       = quad;
      armed_nxt      = armed;
      sr_nxt         = sr;
      byte_sr_nxt    = byte_sr;
      next_byte_nxt  = next_byte;
      next_valid_nxt = next_valid;
      mem_rd_q_nxt   = mem_rd;
      data_out_nxt   = data_out;
      data_oe_nxt    = data_oe;
      mem_addr_nxt   = mem_addr;
      mem_rd_nxt     = 1'b0;
      load           = 1'b0;

      // Read data arrives one clk after the strobe; park it until it is consumed
      if (mem_rd_q) begin
         next_byte_nxt  = mem_data;
         next_valid_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (!cs_n) begin
               state_nxt = CMD;
               cnt_nxt   = '0;
               quad_nxt  = 1'b0;
            end
         end
         CMD: begin
            if (rise) begin
               sr_nxt  = sr_in;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(7)) begin
                  cnt_nxt = '0;
                  case (sr_in[7:0])
                     8'h03: begin
                        state_nxt = ADDR;
                        quad_nxt  = 1'b0;
                     end
                     8'hEB: begin
                        state_nxt = ADDR;
                        quad_nxt  = 1'b1;
                     end
                     8'h9F: begin
                        state_nxt    = ID;
                        sr_nxt       = {JEDEC_ID[22:0], 1'b0};
                        data_out_nxt = {3'b000, JEDEC_ID[23]};
                        data_oe_nxt  = 4'b0001;
                        armed_nxt    = 1'b0;
                     end
                     default: state_nxt = IGNORE;
                  endcase
               end
            end
         end
         ADDR: begin
            if (rise) begin
               sr_nxt  = sr_in;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(23)) begin
                  cnt_nxt        = '0;
                  mem_addr_nxt   = sr_in[ADDR_WIDTH-1:0];
                  mem_rd_nxt     = 1'b1;
                  next_valid_nxt = 1'b0;
                  state_nxt      = (quad && DUMMY_CYCLES != 0) ? DUMMY : LOAD;
               end
            end
         end
         DUMMY: begin
            if (rise) begin
               if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = LOAD;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         LOAD: begin
            if (mem_rd_q || next_valid) begin
               load      = 1'b1;
               armed_nxt = 1'b0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            // Falls count only once a data rise has been seen, so the trailing
            // fall of the address/dummy phase never shifts the first bit away
            if (rise) begin
               armed_nxt = 1'b1;
            end else if (fall && armed) begin
               if (last_bit) begin
                  load = 1'b1;
               end else if (quad) begin
                  byte_sr_nxt  = {byte_sr[3:0], 4'b0000};
                  data_out_nxt = byte_sr[3:0];
                  cnt_nxt      = cnt + CNT_W'(1);
               end else begin
                  byte_sr_nxt  = {byte_sr[6:0], 1'b0};
                  data_out_nxt = {3'b000, byte_sr[6]};
                  cnt_nxt      = cnt + CNT_W'(1);
               end
            end
         end
         ID: begin
            if (rise) begin
               armed_nxt = 1'b1;
            end else if (fall && armed) begin
               sr_nxt       = {sr[22:0], 1'b0};
               data_out_nxt = {3'b000, sr[23]};
            end
         end
         IGNORE: begin
            data_oe_nxt = 4'b0000;
         end
         default: state_nxt = IDLE;
      endcase

      // Present a new byte and prefetch the following address
      if (load) begin
         byte_sr_nxt    = fetch_byte;
         data_out_nxt   = quad ? fetch_byte[7:4] : {3'b000, fetch_byte[7]};
         data_oe_nxt    = quad ? 4'b1111 : 4'b0001;
         cnt_nxt        = '0;
         mem_rd_nxt     = 1'b1;
         mem_addr_nxt   = mem_addr + ADDR_WIDTH'(1);
         next_valid_nxt = 1'b0;
      end

      // Deselect overrides everything, including an edge in the same clk
      if (cs_n) begin
         state_nxt      = IDLE;
         cnt_nxt        = '0;
         armed_nxt      = 1'b0;
         data_oe_nxt    = 4'b0000;
         data_out_nxt   = 4'b0000;
         mem_rd_nxt     = 1'b0;
         mem_rd_q_nxt   = 1'b0;
         next_valid_nxt = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         spi_clk_q  <= 1'b0;
         cnt        <= '0;
         quad       <= 1'b0;
         armed      <= 1'b0;
         sr         <= '0;
         byte_sr    <= '0;
         next_byte  <= '0;
         next_valid <= 1'b0;
         mem_rd_q   <= 1'b0;
         data_out   <= '0;
         data_oe    <= '0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
      end else begin
         state      <= state_nxt;
         spi_clk_q  <= spi_clk;
         cnt        <= cnt_nxt;
         quad       <= quad_nxt;
         armed      <= armed_nxt;
         sr         <= sr_nxt;
         byte_sr    <= byte_sr_nxt;
         next_byte  <= next_byte_nxt;
         next_valid <= next_valid_nxt;
         mem_rd_q   <= mem_rd_q_nxt;
         data_out   <= data_out_nxt;
         data_oe    <= data_oe_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_rd     <= mem_rd_nxt;
      end
   end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: acts as SPI initiator and memory, checks against
// a byte-array flash model.
module tb_qspi_flash_responder;

   localparam int unsigned AW = 16;

   logic          clk;
   logic          reset;
   logic          spi_clk;
   logic          cs_n;
   logic          data_in;
   logic [3:0]    data_out;
   logic [3:0]    data_oe;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [7:0]    mem_data;

   qspi_flash_responder #(
      .ADDR_WIDTH  (AW),
      .DUMMY_CYCLES(6),
      .JEDEC_ID    (24'hEF4016)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .spi_clk (spi_clk),
      .cs_n    (cs_n),
      .data_in (data_in),
      .data_out(data_out),
      .data_oe (data_oe),
      .mem_addr(mem_addr),
      .mem_rd  (mem_rd),
      .mem_data(mem_data)
   );

   logic [7:0]    mem [0:65535];
   logic [AW-1:0] reads[$];
   logic          pend = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   int            checks;
   int            errors;
   int            half;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: data valid only in the clk after the strobe, garbage otherwise
   always @(negedge clk) begin
      mem_data = pend ? mem[pend_addr] : 8'($urandom);
      pend      = mem_rd;
      pend_addr = mem_addr;
      if (mem_rd) reads.push_back(mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One SPI clock: drive MOSI, sample IO just before the rise, then fall
   task automatic sck(input logic mosi, output logic [3:0] io, output logic [3:0] oe);
      data_in = mosi;
      repeat (half) @(negedge clk);
      io = data_out;
      oe = data_oe;
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic select(input bit clk_high);
      @(negedge clk);
      spi_clk = clk_high;
      repeat (2) @(negedge clk);
      cs_n = 1'b0;
      repeat (2) @(negedge clk);
      if (clk_high) begin
         spi_clk = 1'b0;
         repeat (half) @(negedge clk);
      end
   endtask

   task automatic deselect();
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      check("deselect_oe", 32'(data_oe), 32'(4'h0));
   endtask

   task automatic send_bits(input logic [23:0] v, input int n, input string tag);
      logic [3:0] io, oe;
      for (int i = n - 1; i >= 0; i--) begin
         sck(v[i], io, oe);
         check(tag, 32'(oe), 32'(4'h0));
      end
   endtask

   task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input int nrx,
                          input int rst_at, input bit clk_high);
      logic [3:0]    io, oe, exp_nib;
      logic [7:0]    b;
      logic [AW-1:0] base;
      bit            q;
      int            nrd;
      q    = (cmd == 8'hEB);
      half = $urandom_range(2, 4);
      base = addr[AW-1:0];
      reads.delete();
      select(clk_high);
      send_bits({16'h0, cmd}, 8, "cmd_oe");
      send_bits(addr, 24, "addr_oe");
      if (q) send_bits(24'($urandom), 6, "dummy_oe");
      for (int i = 0; i < nrx; i++) begin
         if (i == rst_at) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("rst_oe", 32'(data_oe), 32'(4'h0));
            check("rst_out", 32'(data_out), 32'(4'h0));
            check("rst_rd", 32'(mem_rd), 32'(1'b0));
            check("rst_addr", 32'(mem_addr), 32'(16'h0));
            cs_n    = 1'b1;
            spi_clk = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            return;
         end
         sck(1'($urandom), io, oe);
         if (q) begin
            b       = mem[AW'(base + AW'(i / 2))];
            exp_nib = (i % 2 == 1) ? b[3:0] : b[7:4];
            check("quad_nib", 32'(io), 32'(exp_nib));
            check("quad_oe", 32'(oe), 32'(4'hF));
         end else begin
            b = mem[AW'(base + AW'(i / 8))];
            check("ser_bit", 32'(io[0]), 32'(b[7 - (i % 8)]));
            check("ser_oe", 32'(oe), 32'(4'h1));
         end
      end
      deselect();
      // initial read, one prefetch at first load, one more per byte boundary crossed
      nrd = 2 + nrx / (q ? 2 : 8);
      check("rd_count", 32'(reads.size()), 32'(nrd));
      for (int k = 0; k < reads.size() && k < nrd; k++)
         check("rd_addr", 32'(reads[k]), 32'(AW'(base + AW'(k))));
   endtask

   task automatic do_jedec();
      logic [3:0]  io, oe;
      logic [23:0] id;
      logic        exp_bit;
      id   = 24'hEF4016;
      half = $urandom_range(2, 4);
      select(1'b0);
      send_bits(24'h00009F, 8, "cmd_oe");
      for (int i = 0; i < 28; i++) begin
         sck(1'($urandom), io, oe);
         exp_bit = (i < 24) ? id[23 - i] : 1'b0;
         check("id_bit", 32'(io[0]), 32'(exp_bit));
         check("id_oe", 32'(oe), 32'(4'h1));
      end
      deselect();
   endtask

   task automatic do_ignore();
      logic [3:0] io, oe;
      half = 2;
      reads.delete();
      select(1'b0);
      send_bits(24'h000005, 8, "cmd_oe");
      for (int i = 0; i < 16; i++) begin
         sck(1'($urandom), io, oe);
         check("ign_oe", 32'(oe), 32'(4'h0));
      end
      deselect();
      check("ign_rd", 32'(reads.size()), 32'(0));
   endtask

   task automatic do_abort();
      half = 3;
      reads.delete();
      select(1'b0);
      send_bits(24'h000003, 8, "cmd_oe");
      send_bits(24'h000002, 12, "addr_oe");
      deselect();
      repeat (4) @(negedge clk);
      check("abort_rd", 32'(reads.size()), 32'(0));
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      half    = 2;
      reset   = 1'b1;
      cs_n    = 1'b1;
      spi_clk = 1'b0;
      data_in = 1'b0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;
      mem[16'h0100] = 8'h12;
      mem[16'h0101] = 8'h34;

      repeat (3) @(negedge clk);
      check("reset_oe", 32'(data_oe), 32'(4'h0));
      check("reset_out", 32'(data_out), 32'(4'h0));
      check("reset_rd", 32'(mem_rd), 32'(1'b0));
      check("reset_addr", 32'(mem_addr), 32'(16'h0));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      do_read(8'h03, 24'h000010, 16, -1, 1'b0);
      do_read(8'hEB, 24'h000100, 4, -1, 1'b0);
      do_read(8'h03, 24'h00FFFF, 16, -1, 1'b0);
      do_jedec();
      do_ignore();
      do_abort();
      do_read(8'h03, 24'h000020, 8, -1, 1'b0);
      do_read(8'h03, 24'h000040, 20, 5, 1'b0);
      do_read(8'hEB, 24'h123456, 6, -1, 1'b0);
      do_read(8'hEB, 24'hFFFFFF, 3, -1, 1'b0);

      for (int k = 0; k < 6; k++)
         do_read(($urandom_range(0, 1) == 1) ? 8'hEB : 8'h03, 24'($urandom),
                 $urandom_range(1, 24), -1, (k == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
